// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised input level, per-bit edge capture with
// write-1-to-clear semantics and a maskable level interrupt.
module pio_in_edge_capture #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [31:0] RESET_EDGESEL = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_EDGESEL = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam logic [2:0] ARM_LAST     = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] edgesel_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [2:0]       arm_cnt_r;
  logic             armed_r;

  logic [WIDTH-1:0] s_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] event_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edgecap_nxt_s;
  logic [WIDTH-1:0] irqmask_nxt_s;
  logic [WIDTH-1:0] edgesel_nxt_s;

  // Zero-extend a WIDTH-bit register onto the 32-bit bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign s_s     = sync_r[SYNC_STAGES-1];
  assign wr_en_s = chipselect & ~write_n;

  // Next-state logic for edge detection, capture and the writable registers.
  always_comb begin
    event_s       = '0;
    clr_s         = '0;
    edgesel_nxt_s = edgesel_r;
    irqmask_nxt_s = irqmask_r;
    if (armed_r) begin
      event_s = (s_s & ~p_r & ~edgesel_r) | (~s_s & p_r & edgesel_r);
    end else begin
      event_s = '0;
    end
    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_en_s && (address == ADDR_EDGESEL)) begin
      edgesel_nxt_s = writedata[WIDTH-1:0];
    end else begin
      edgesel_nxt_s = edgesel_r;
    end
    if (wr_en_s && (address == ADDR_IRQMASK)) begin
      irqmask_nxt_s = writedata[WIDTH-1:0];
    end else begin
      irqmask_nxt_s = irqmask_r;
    end
    // A new event outranks a simultaneous clear.
    edgecap_nxt_s = (edgecap_r & ~clr_s) | event_s;
  end

  // Input synchroniser chain plus the one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      p_r    <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
      p_r    <= s_s;
    end
  end

  // Arming counter: suppresses spurious edges while the chain fills after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_r <= 3'd0;
      armed_r   <= 1'b0;
    end else if (!armed_r) begin
      if (arm_cnt_r == ARM_LAST) begin
        armed_r <= 1'b1;
      end else begin
        arm_cnt_r <= arm_cnt_r + 3'd1;
      end
    end else begin
      armed_r   <= armed_r;
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Control/status registers and the interrupt, computed from next state so
  // irq tracks EDGECAP and IRQMASK on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgesel_r <= RESET_EDGESEL[WIDTH-1:0];
      irqmask_r <= '0;
      edgecap_r <= '0;
      irq       <= 1'b0;
    end else begin
      edgesel_r <= edgesel_nxt_s;
      irqmask_r <= irqmask_nxt_s;
      edgecap_r <= edgecap_nxt_s;
      irq       <= |(edgecap_nxt_s & irqmask_nxt_s);
    end
  end

  // Read mux, reloaded every clock from pre-edge register contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0000_0000;
    end else begin
      case (address)
        ADDR_DATA:    readdata <= zext(s_s);
        ADDR_EDGESEL: readdata <= zext(edgesel_r);
        ADDR_IRQMASK: readdata <= zext(irqmask_r);
        ADDR_EDGECAP: readdata <= zext(edgecap_r);
        default:      readdata <= 32'h0000_0000;
      endcase
    end
  end

endmodule
